// File: rtl/acq_pkg.sv
// Shared types, default widths and the buffer-capacity arithmetic for the
// acquisition run sequencer.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ARM,
        ST_RUN,
        ST_FINISH
    } acq_state_t;

    localparam int CNT_W_DEF      = 24;
    localparam int ADDR_W_DEF     = 32;
    localparam int TMO_W_DEF      = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTES_SHIFT    = $clog2(BYTES_PER_WORD);
    localparam int PROD_W         = 2 * CNT_W_DEF + 1;
    localparam int BYTES_W        = PROD_W + BYTES_SHIFT;

    // Total words a run will write: (samples-per-record) x (records), full width.
    function automatic logic [PROD_W-1:0] run_words(input logic [CNT_W_DEF-1:0] sample_cnt,
                                                    input logic [CNT_W_DEF-1:0] rep_cnt);
        logic [CNT_W_DEF:0] samples;
        samples = {1'b0, sample_cnt} + (CNT_W_DEF + 1)'(1);
        return PROD_W'(samples) * PROD_W'(rep_cnt);
    endfunction

    // True when the whole run fits in the capture buffer without truncation.
    function automatic logic fits_buffer(input logic [CNT_W_DEF-1:0] sample_cnt,
                                         input logic [CNT_W_DEF-1:0] rep_cnt,
                                         input logic [BYTES_W-1:0]   mem_bytes);
        logic [BYTES_W-1:0] bytes;
        bytes = BYTES_W'(run_words(sample_cnt, rep_cnt)) << BYTES_SHIFT;
        return bytes <= mem_bytes;
    endfunction

endpackage

// File: rtl/acq_watchdog.sv
// Trigger watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches the loaded limit (limit 0 = off).
module acq_watchdog
    import acq_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMO_W-1:0] limit,
    input  logic             clear,
    input  logic             enable,
    output logic             expire
);

    logic [TMO_W-1:0] limit_q;
    logic [TMO_W-1:0] count;

    // Limit is captured once per run; the count restarts on load or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q <= '0;
            count   <= '0;
        end else if (load) begin
            limit_q <= limit;
            count   <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expire = enable & ~clear & (limit_q != '0) & (count == limit_q - TMO_W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Run-level controller for the two-channel capture engine: validates and
// latches settings, arms the engine, counts records and enforces a timeout.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TMO_W     = TMO_W_DEF,
    parameter int MEM_BYTES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_sample_cnt,
    input  logic [CNT_W-1:0]  cfg_rep_cnt,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              cap_write_enable,
    output logic [CNT_W-1:0]  cap_max_sample_cnt,
    output logic [CNT_W-1:0]  cap_max_repetition_cnt,
    output logic              cap_arm,
    output logic              cap_rst,
    output logic              busy,
    output logic              done,
    output logic              err_config,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              err_count,
    output logic [CNT_W-1:0]  records_done,
    output logic [ADDR_W-1:0] words_written
);

    acq_state_t        state, next_state;
    logic              we_prev;
    logic              aborted;
    logic [ADDR_W-1:0] exp_words;
    logic              accept, fall, rec_last;
    logic              wd_clear, wd_enable, wd_expire;
    logic              abort_run, set_config, set_overflow, set_timeout;

    assign fall      = we_prev & ~cap_write_enable;
    assign accept    = (state == ST_IDLE) & start & ~abort;
    assign rec_last  = fall & ((records_done + CNT_W'(1)) == cap_max_repetition_cnt);
    assign wd_clear  = (state == ST_ARM) | fall;
    assign wd_enable = (state == ST_RUN);
    assign cap_arm   = (state == ST_ARM);

    acq_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .limit  (cfg_timeout),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state decode and the one-shot events that feed the datapath.
    always_comb begin
        next_state   = state;
        abort_run    = 1'b0;
        set_config   = 1'b0;
        set_overflow = 1'b0;
        set_timeout  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort) begin
                    abort_run  = 1'b1;
                    next_state = ST_FINISH;
                end else if (cap_max_repetition_cnt == '0) begin
                    set_config = 1'b1;
                    next_state = ST_FINISH;
                end else if (!fits_buffer(cap_max_sample_cnt, cap_max_repetition_cnt,
                                          BYTES_W'(MEM_BYTES))) begin
                    set_overflow = 1'b1;
                    next_state   = ST_FINISH;
                end else begin
                    next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) abort_run = 1'b1;
                next_state = abort ? ST_FINISH : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    abort_run  = 1'b1;
                    next_state = ST_FINISH;
                end else if (rec_last) begin
                    next_state = ST_FINISH;
                end else if (wd_expire) begin
                    set_timeout = 1'b1;
                    next_state  = ST_FINISH;
                end
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Latched config, run counters and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_prev                <= 1'b0;
            aborted                <= 1'b0;
            exp_words              <= '0;
            cap_max_sample_cnt     <= '0;
            cap_max_repetition_cnt <= '0;
            cap_rst                <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err_config             <= 1'b0;
            err_overflow           <= 1'b0;
            err_timeout            <= 1'b0;
            err_count              <= 1'b0;
            records_done           <= '0;
            words_written          <= '0;
        end else begin
            we_prev <= cap_write_enable;
            cap_rst <= abort_run | set_timeout;
            if (accept) begin
                cap_max_sample_cnt     <= cfg_sample_cnt;
                cap_max_repetition_cnt <= cfg_rep_cnt;
                busy                   <= 1'b1;
                done                   <= 1'b0;
                err_config             <= 1'b0;
                err_overflow           <= 1'b0;
                err_timeout            <= 1'b0;
                err_count              <= 1'b0;
                records_done           <= '0;
                words_written          <= '0;
                aborted                <= 1'b0;
            end
            if (abort_run)    aborted      <= 1'b1;
            if (set_config)   err_config   <= 1'b1;
            if (set_overflow) err_overflow <= 1'b1;
            if (set_timeout)  err_timeout  <= 1'b1;
            if (state == ST_CHECK)
                exp_words <= ADDR_W'(run_words(cap_max_sample_cnt, cap_max_repetition_cnt));
            if (state == ST_RUN) begin
                if (cap_write_enable) words_written <= words_written + ADDR_W'(1);
                if (fall)             records_done  <= records_done + CNT_W'(1);
            end
            if (state == ST_FINISH) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (!aborted && !err_config && !err_overflow && !err_timeout &&
                    (words_written != exp_words))
                    err_count <= 1'b1;
            end
        end
    end

endmodule
